// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the MemController port between instruction fetch (I) and data (D),
// with a stall watchdog. Define MEM_ARB_STATS_EN to add per-requester completion counters.
module mem_port_arbiter #(
    parameter int unsigned       ADDR_W         = 32,
    parameter int unsigned       DATA_W         = 32,
    parameter int unsigned       TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_W-1:0] ABORT_DATA     = 32'hDEADBEEF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              I_En,
    input  logic [ADDR_W-1:0] I_Address,
    output logic              I_Stall,
    output logic [DATA_W-1:0] I_OData,
    input  logic              D_En,
    input  logic              D_RW,
    input  logic [ADDR_W-1:0] D_Address,
    input  logic [DATA_W-1:0] D_IData,
    output logic              D_Stall,
    output logic [DATA_W-1:0] D_OData,
    output logic              M_En,
    output logic              M_RW,
    output logic [ADDR_W-1:0] M_Address,
    output logic [DATA_W-1:0] M_IData,
    input  logic              M_Stall,
    input  logic [DATA_W-1:0] M_OData,
`ifdef MEM_ARB_STATS_EN
    output logic [31:0]       I_GrantCount,
    output logic [31:0]       D_GrantCount,
`endif
    output logic              Err
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;
    typedef enum logic {LAST_I, LAST_D} last_t;

    localparam int unsigned       CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic              WDOG_EN  = (TIMEOUT_CYCLES != 0);

    state_t           state_q, state_d;
    last_t            last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             abort;
    logic             complete_i, complete_d;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            last_q  <= LAST_I;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        M_En       = 1'b0;
        M_RW       = 1'b0;
        M_Address  = '0;
        M_IData    = '0;
        I_Stall    = I_En;
        D_Stall    = D_En;
        I_OData    = '0;
        D_OData    = '0;
        Err        = 1'b0;
        abort      = 1'b0;
        complete_i = 1'b0;
        complete_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (I_En && D_En)
                    state_d = (last_q == LAST_I) ? GNT_D : GNT_I;
                else if (I_En)
                    state_d = GNT_I;
                else if (D_En)
                    state_d = GNT_D;
            end
            GNT_I: begin
                abort      = WDOG_EN && I_En && M_Stall && (cnt_q == CNT_LAST);
                M_En       = I_En && !abort;
                M_Address  = I_Address;
                I_Stall    = M_Stall && !abort;
                I_OData    = abort ? ABORT_DATA : M_OData;
                Err        = abort;
                complete_i = I_En && (!M_Stall || abort);
                if (complete_i) begin
                    last_d  = LAST_I;
                    state_d = D_En ? GNT_D : GNT_I;
                end else if (!I_En) begin
                    state_d = IDLE;
                end
            end
            GNT_D: begin
                abort      = WDOG_EN && D_En && M_Stall && (cnt_q == CNT_LAST);
                M_En       = D_En && !abort;
                M_RW       = D_RW;
                M_Address  = D_Address;
                M_IData    = D_IData;
                D_Stall    = M_Stall && !abort;
                D_OData    = abort ? ABORT_DATA : M_OData;
                Err        = abort;
                complete_d = D_En && (!M_Stall || abort);
                if (complete_d) begin
                    last_d  = LAST_D;
                    state_d = I_En ? GNT_I : GNT_D;
                end else if (!D_En) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Watchdog restarts for every new access; saturates rather than wrapping.
        if (complete_i || complete_d || (state_d != state_q))
            cnt_d = '0;
        else if (WDOG_EN && M_En && M_Stall && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            I_GrantCount <= '0;
            D_GrantCount <= '0;
        end else begin
            if (complete_i)
                I_GrantCount <= I_GrantCount + 32'd1;
            if (complete_d)
                D_GrantCount <= D_GrantCount + 32'd1;
        end
    end
`else
    // No completion counters in this build.
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int unsigned TO    = 8;
    localparam logic [31:0] ABORT = 32'hDEADBEEF;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        I_En, D_En, D_RW, M_Stall;
    logic [31:0] I_Address, D_Address, D_IData, M_OData;
    logic        I_Stall, D_Stall, M_En, M_RW, Err;
    logic [31:0] I_OData, D_OData, M_Address, M_IData;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] I_GrantCount, D_GrantCount;
`endif

    int checks = 0;
    int fails  = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO), .ABORT_DATA(ABORT)) dut (
        .Clk(Clk), .Rst(Rst),
        .I_En(I_En), .I_Address(I_Address), .I_Stall(I_Stall), .I_OData(I_OData),
        .D_En(D_En), .D_RW(D_RW), .D_Address(D_Address), .D_IData(D_IData),
        .D_Stall(D_Stall), .D_OData(D_OData),
        .M_En(M_En), .M_RW(M_RW), .M_Address(M_Address), .M_IData(M_IData),
        .M_Stall(M_Stall), .M_OData(M_OData),
`ifdef MEM_ARB_STATS_EN
        .I_GrantCount(I_GrantCount), .D_GrantCount(D_GrantCount),
`endif
        .Err(Err)
    );

    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        I_En = 1'b0; D_En = 1'b0; D_RW = 1'b0; M_Stall = 1'b0;
    endtask

    task automatic test_reset();
        Rst = 1'b1; I_En = 1'b1; D_En = 1'b1; D_RW = 1'b0;
        I_Address = 32'h100; D_Address = 32'h200; D_IData = '0;
        M_Stall = 1'b0; M_OData = 32'h11111111;
        repeat (2) @(negedge Clk);
        checks++; if (M_En !== 1'b0) begin fails++; $display("FAIL reset_m_en: got %b want 0", M_En); end
        checks++; if (I_Stall !== 1'b1) begin fails++; $display("FAIL reset_i_stall: got %b want 1", I_Stall); end
        checks++; if (D_Stall !== 1'b1) begin fails++; $display("FAIL reset_d_stall: got %b want 1", D_Stall); end
        checks++; if (I_OData !== 32'h0 || D_OData !== 32'h0) begin fails++; $display("FAIL reset_odata: got %h/%h want 0/0", I_OData, D_OData); end
        checks++; if (Err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", Err); end
        Rst = 1'b0;
        @(negedge Clk);
        checks++; if (M_En !== 1'b1 || M_Address !== 32'h200) begin fails++; $display("FAIL first_grant_d: got en=%b addr=%h want 1/200", M_En, M_Address); end
        checks++; if (D_Stall !== 1'b0 || D_OData !== 32'h11111111) begin fails++; $display("FAIL first_d_done: got stall=%b data=%h want 0/11111111", D_Stall, D_OData); end
        checks++; if (I_Stall !== 1'b1) begin fails++; $display("FAIL first_i_wait: got %b want 1", I_Stall); end
        tick(); D_En = 1'b0;
        @(negedge Clk);
        checks++; if (M_Address !== 32'h100 || M_RW !== 1'b0 || I_Stall !== 1'b0) begin fails++; $display("FAIL then_grant_i: got addr=%h rw=%b stall=%b want 100/0/0", M_Address, M_RW, I_Stall); end
        checks++; if (I_OData !== 32'h11111111 || D_OData !== 32'h0) begin fails++; $display("FAIL then_i_data: got %h/%h want 11111111/0", I_OData, D_OData); end
        tick(); I_En = 1'b0;
        tick();
    endtask

    task automatic test_stall_read();
        D_En = 1'b1; D_RW = 1'b0; D_Address = 32'h10004; I_En = 1'b1; I_Address = 32'h2000;
        M_Stall = 1'b1; M_OData = 32'h12345678;
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            checks++; if (D_Stall !== 1'b1 || I_Stall !== 1'b1) begin fails++; $display("FAIL stall_read_wait%0d: got d=%b i=%b want 1/1", k, D_Stall, I_Stall); end
            checks++; if (M_En !== 1'b1 || M_Address !== 32'h10004) begin fails++; $display("FAIL stall_read_port%0d: got en=%b addr=%h want 1/10004", k, M_En, M_Address); end
            tick();
        end
        M_Stall = 1'b0;
        @(negedge Clk);
        checks++; if (D_Stall !== 1'b0 || D_OData !== 32'h12345678) begin fails++; $display("FAIL stall_read_done: got stall=%b data=%h want 0/12345678", D_Stall, D_OData); end
        checks++; if (I_Stall !== 1'b1) begin fails++; $display("FAIL stall_read_i_held: got %b want 1", I_Stall); end
        tick(); D_En = 1'b0;
        @(negedge Clk);
        checks++; if (I_Stall !== 1'b0 || M_Address !== 32'h2000) begin fails++; $display("FAIL stall_read_i_next: got stall=%b addr=%h want 0/2000", I_Stall, M_Address); end
        tick(); I_En = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic exp_d;
        I_Address = $urandom & 32'hFFFF_FFFE; D_Address = $urandom | 32'h1;
        I_En = 1'b1; D_En = 1'b1; D_RW = 1'b0; M_Stall = 1'b0;
        tick();
        for (int k = 0; k < 8; k++) begin
            M_OData = $urandom;
            @(negedge Clk);
            exp_d = (k % 2 == 0);
            checks++; if (M_En !== 1'b1 || M_Address !== (exp_d ? D_Address : I_Address)) begin fails++; $display("FAIL b2b_grant%0d: got en=%b addr=%h want 1/%h", k, M_En, M_Address, exp_d ? D_Address : I_Address); end
            checks++; if ({D_Stall, I_Stall} !== (exp_d ? 2'b01 : 2'b10)) begin fails++; $display("FAIL b2b_stall%0d: got d=%b i=%b want d=%b i=%b", k, D_Stall, I_Stall, !exp_d, exp_d); end
            checks++; if ((exp_d ? D_OData : I_OData) !== M_OData || (exp_d ? I_OData : D_OData) !== 32'h0) begin fails++; $display("FAIL b2b_data%0d: got i=%h d=%h want owner=%h other=0", k, I_OData, D_OData, M_OData); end
            tick();
        end
        I_En = 1'b0; D_En = 1'b0;
        tick();
    endtask

    task automatic test_watchdog();
        D_En = 1'b1; D_RW = 1'b0; D_Address = 32'h3000; I_En = 1'b1; I_Address = 32'h4000;
        M_Stall = 1'b1; M_OData = 32'h0;
        tick();
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clk);
            if (k < 8) begin
                checks++; if (Err !== 1'b0 || D_Stall !== 1'b1 || M_En !== 1'b1) begin fails++; $display("FAIL wdog_wait%0d: got err=%b stall=%b en=%b want 0/1/1", k, Err, D_Stall, M_En); end
            end else begin
                checks++; if (Err !== 1'b1 || D_Stall !== 1'b0 || M_En !== 1'b0) begin fails++; $display("FAIL wdog_abort: got err=%b stall=%b en=%b want 1/0/0", Err, D_Stall, M_En); end
                checks++; if (D_OData !== ABORT || I_Stall !== 1'b1) begin fails++; $display("FAIL wdog_abort_data: got %h i_stall=%b want %h/1", D_OData, I_Stall, ABORT); end
            end
            tick();
        end
        D_En = 1'b0;
        @(negedge Clk);
        checks++; if (Err !== 1'b0 || I_Stall !== 1'b1 || M_En !== 1'b1 || M_Address !== 32'h4000) begin fails++; $display("FAIL wdog_next_i: got err=%b stall=%b en=%b addr=%h want 0/1/1/4000", Err, I_Stall, M_En, M_Address); end
        tick(); M_Stall = 1'b0;
        @(negedge Clk);
        checks++; if (I_Stall !== 1'b0) begin fails++; $display("FAIL wdog_i_done: got %b want 0", I_Stall); end
        tick(); I_En = 1'b0;
        tick();
    endtask

    task automatic test_write_and_drop();
        D_En = 1'b1; D_RW = 1'b1; D_IData = 32'hA5A5A5A5; D_Address = $urandom; M_Stall = 1'b1;
        tick();
        @(negedge Clk);
        checks++; if (M_En !== 1'b1 || M_RW !== 1'b1 || M_IData !== 32'hA5A5A5A5) begin fails++; $display("FAIL write_port: got en=%b rw=%b data=%h want 1/1/a5a5a5a5", M_En, M_RW, M_IData); end
        checks++; if (M_Address !== D_Address) begin fails++; $display("FAIL write_addr: got %h want %h", M_Address, D_Address); end
        tick(); D_En = 1'b0;
        @(negedge Clk);
        checks++; if (M_En !== 1'b0 || Err !== 1'b0) begin fails++; $display("FAIL drop_same_cycle: got en=%b err=%b want 0/0", M_En, Err); end
        tick(); D_En = 1'b1; D_RW = 1'b0; M_Stall = 1'b0;
        @(negedge Clk);
        checks++; if (M_En !== 1'b0 || D_Stall !== 1'b1) begin fails++; $display("FAIL drop_to_idle: got en=%b stall=%b want 0/1", M_En, D_Stall); end
        tick();
        @(negedge Clk);
        checks++; if (D_Stall !== 1'b0 || M_RW !== 1'b0) begin fails++; $display("FAIL read_after_drop: got stall=%b rw=%b want 0/0", D_Stall, M_RW); end
        tick(); D_En = 1'b0;
        tick(); I_En = 1'b1; I_Address = $urandom; M_OData = $urandom;
        tick();
        @(negedge Clk);
        checks++; if (M_En !== 1'b1 || M_RW !== 1'b0 || M_Address !== I_Address) begin fails++; $display("FAIL fetch_port: got en=%b rw=%b addr=%h want 1/0/%h", M_En, M_RW, M_Address, I_Address); end
        checks++; if (I_Stall !== 1'b0 || I_OData !== M_OData) begin fails++; $display("FAIL fetch_data: got stall=%b data=%h want 0/%h", I_Stall, I_OData, M_OData); end
        tick(); I_En = 1'b0;
        tick();
    endtask

`ifdef MEM_ARB_STATS_EN
    task automatic test_stats();
        int exp_i = 5;
        int exp_d = 3;
        @(negedge Clk); Rst = 1'b1; idle_inputs();
        @(negedge Clk); Rst = 1'b0;
        tick(); D_En = 1'b1; M_Stall = 1'b1;
        tick();
        repeat (8) tick();
        D_En = 1'b0; M_Stall = 1'b0;
        tick(); I_En = 1'b1;
        tick();
        repeat (5) tick();
        I_En = 1'b0;
        tick(); D_En = 1'b1;
        tick();
        repeat (2) tick();
        D_En = 1'b0;
        tick();
        @(negedge Clk);
        checks++; if (I_GrantCount !== 32'(exp_i)) begin fails++; $display("FAIL stats_i: got %0d want %0d", I_GrantCount, exp_i); end
        checks++; if (D_GrantCount !== 32'(exp_d)) begin fails++; $display("FAIL stats_d: got %0d want %0d", D_GrantCount, exp_d); end
    endtask
`endif

    task automatic test_async_reset();
        D_En = 1'b1; D_RW = 1'b0; M_Stall = 1'b1;
        tick();
        @(negedge Clk);
        checks++; if (M_En !== 1'b1) begin fails++; $display("FAIL areset_inflight: got %b want 1", M_En); end
        #2 Rst = 1'b1;
        #1;
        checks++; if (M_En !== 1'b0 || D_Stall !== 1'b1 || D_OData !== 32'h0) begin fails++; $display("FAIL areset_now: got en=%b stall=%b data=%h want 0/1/0", M_En, D_Stall, D_OData); end
`ifdef MEM_ARB_STATS_EN
        checks++; if (I_GrantCount !== 32'h0 || D_GrantCount !== 32'h0) begin fails++; $display("FAIL areset_stats: got %0d/%0d want 0/0", I_GrantCount, D_GrantCount); end
`endif
        @(negedge Clk); Rst = 1'b0; idle_inputs();
        tick();
    endtask

    task automatic test_random();
        int          owner;
        int          last_r;
        int          cnt;
        int          streak;
        int          x, o;
        int          n_done[2];
        logic        en[2];
        logic        done[2];
        logic        ab, e_men, fin;
        logic [1:0]  e_stall, a_stall;
        logic [31:0] e_odata[2];
        logic [31:0] a_odata[2];
        logic [31:0] e_addr;
        @(negedge Clk); Rst = 1'b1; idle_inputs();
        @(negedge Clk); Rst = 1'b0;
        owner = -1; last_r = 0; cnt = 0; streak = 0;
        n_done[0] = 0; n_done[1] = 0;
        en[0] = 1'b0; en[1] = 1'b0; done[0] = 1'b0; done[1] = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            tick();
            for (int r = 0; r < 2; r++) begin
                if (!(en[r] && !done[r])) begin
                    en[r] = ($urandom_range(0, 2) != 0);
                    if (r == 0) begin
                        I_Address = $urandom;
                    end else begin
                        D_RW = 1'($urandom_range(0, 1)); D_Address = $urandom; D_IData = $urandom;
                    end
                end
            end
            I_En = en[0]; D_En = en[1];
            if (streak > 0) begin
                M_Stall = 1'b1; streak--;
            end else if ($urandom_range(0, 29) == 0) begin
                M_Stall = 1'b1; streak = 11;
            end else begin
                M_Stall = ($urandom_range(0, 3) == 0);
            end
            M_OData = $urandom;

            @(negedge Clk);
            ab = 1'b0; e_men = 1'b0; e_addr = '0;
            e_stall = {en[1], en[0]};
            e_odata[0] = '0; e_odata[1] = '0;
            x = (owner < 0) ? 0 : owner;
            o = 1 - x;
            if (owner >= 0) begin
                ab = en[x] && M_Stall && (cnt == TO - 1);
                e_men = en[x] && !ab;
                e_stall[x] = ab ? 1'b0 : M_Stall;
                e_odata[x] = ab ? ABORT : M_OData;
                e_addr = (x == 0) ? I_Address : D_Address;
            end
            a_stall = {D_Stall, I_Stall};
            a_odata[0] = I_OData; a_odata[1] = D_OData;
            checks++; if (M_En !== e_men) begin fails++; $display("FAIL rnd_m_en @%0d: got %b want %b", cyc, M_En, e_men); end
            checks++; if (Err !== ab) begin fails++; $display("FAIL rnd_err @%0d: got %b want %b", cyc, Err, ab); end
            for (int r = 0; r < 2; r++) begin
                checks++; if (a_odata[r] !== e_odata[r]) begin fails++; $display("FAIL rnd_odata%0d @%0d: got %h want %h", r, cyc, a_odata[r], e_odata[r]); end
                if (en[r]) begin
                    checks++; if (a_stall[r] !== e_stall[r]) begin fails++; $display("FAIL rnd_stall%0d @%0d: got %b want %b", r, cyc, a_stall[r], e_stall[r]); end
                end
            end
            if (e_men) begin
                checks++; if (M_Address !== e_addr || M_RW !== (x == 1 && D_RW)) begin fails++; $display("FAIL rnd_port @%0d: got addr=%h rw=%b want %h/%b", cyc, M_Address, M_RW, e_addr, x == 1 && D_RW); end
                if (x == 1 && D_RW) begin
                    checks++; if (M_IData !== D_IData) begin fails++; $display("FAIL rnd_wdata @%0d: got %h want %h", cyc, M_IData, D_IData); end
                end
            end

            done[0] = 1'b0; done[1] = 1'b0;
            if (owner < 0) begin
                cnt = 0;
                if (en[0] && en[1]) owner = 1 - last_r;
                else if (en[0]) owner = 0;
                else if (en[1]) owner = 1;
            end else begin
                fin = en[x] && (!M_Stall || ab);
                if (fin) begin
                    done[x] = 1'b1; n_done[x]++; last_r = x; cnt = 0;
                    owner = en[o] ? o : x;
                end else if (en[x]) begin
                    cnt++;
                end else begin
                    owner = -1; cnt = 0;
                end
            end
        end
        tick();
`ifdef MEM_ARB_STATS_EN
        @(negedge Clk);
        checks++; if (I_GrantCount !== 32'(n_done[0])) begin fails++; $display("FAIL rnd_stats_i: got %0d want %0d", I_GrantCount, n_done[0]); end
        checks++; if (D_GrantCount !== 32'(n_done[1])) begin fails++; $display("FAIL rnd_stats_d: got %0d want %0d", D_GrantCount, n_done[1]); end
`endif
        idle_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_stall_read();
        test_back_to_back();
        test_watchdog();
        test_write_and_drop();
`ifdef MEM_ARB_STATS_EN
        test_stats();
`endif
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
